// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM, optional parity.
// Delivers every frame, with parity/framing flags held until the next data_valid.
module uart_rx #(
    parameter int parity_on           = 1,
    parameter int data_size           = 8,
    parameter int sampling_cntr_width = 4,
    parameter int even_parity         = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           Rx_s,
    input  logic [sampling_cntr_width-1:0] prescale,
    output logic [data_size-1:0]           Rx_data,
    output logic                           data_valid,
    output logic                           parity_err,
    output logic                           framing_err,
    output logic                           busy
);
    // state  | meaning
    // IDLE   | line idle, prescale latched, waiting for falling edge (once re-armed)
    // START  | waiting for mid start bit; high there means a glitch
    // DATA   | sampling data_size bits, LSB first
    // PARITY | sampling and checking the parity bit
    // STOP   | sampling the stop bit; frame delivered on the sample
    localparam int SW = sampling_cntr_width;
    localparam int BW = (data_size > 1) ? $clog2(data_size) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(data_size - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               r_state, w_next;
    logic                 r_sync, r_rx_q, r_armed, r_perr;
    logic [SW-1:0]        r_bit_len, r_cnt, w_end;
    logic [BW-1:0]        r_bits_cnt;
    logic [data_size-1:0] r_shift;
    logic                 w_tick, w_par_exp;

    assign w_end     = (r_state == START) ? (r_bit_len >> 1) : r_bit_len;
    assign w_tick    = (r_state != IDLE) && (r_cnt == w_end);
    assign w_par_exp = (even_parity != 0) ? ^r_shift : ~^r_shift;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!r_rx_q && r_armed) w_next = START;
            START:   if (w_tick) w_next = r_rx_q ? IDLE : DATA;
            DATA:    if (w_tick && (r_bits_cnt == LAST_BIT))
                         w_next = (parity_on != 0) ? PARITY : STOP;
            PARITY:  if (w_tick) w_next = STOP;
            STOP:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= 1'b1;
            r_rx_q      <= 1'b1;
            r_armed     <= 1'b0;
            r_perr      <= 1'b0;
            r_bit_len   <= '0;
            r_cnt       <= '0;
            r_bits_cnt  <= '0;
            r_shift     <= '0;
            Rx_data     <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            r_sync     <= Rx_s;
            r_rx_q     <= r_sync;
            data_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_bit_len <= prescale;
                r_cnt     <= '0;
                // Re-arm only after seeing the line high, so a held-low break never restarts a frame.
                r_armed   <= r_rx_q;
            end else begin
                r_cnt <= w_tick ? '0 : r_cnt + SW'(1);
            end
            case (r_state)
                START: begin
                    r_bits_cnt <= '0;
                    r_perr     <= 1'b0;
                end
                DATA: if (w_tick) begin
                    r_shift[r_bits_cnt] <= r_rx_q;
                    r_bits_cnt          <= r_bits_cnt + BW'(1);
                end
                PARITY: if (w_tick) r_perr <= (parity_on != 0) && (r_rx_q != w_par_exp);
                STOP: if (w_tick) begin
                    Rx_data     <= r_shift;
                    data_valid  <= 1'b1;
                    parity_err  <= r_perr;
                    framing_err <= ~r_rx_q;
                end
                default: ;
            endcase
        end
    end
endmodule
